// File: rtl/data_mem_responder.sv
// Responder end of the core data-cache port: fixed-latency load/store
// completion against a byte-lane-masked, word-organised local RAM.
module data_mem_responder #(
    parameter int DATA_WIDTH      = 32,
    parameter int BYTE_DATA_WIDTH = 4,
    parameter int DEPTH_LOG2      = 10,
    parameter int LATENCY         = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       data_req,
    input  logic                       data_we,
    input  logic [BYTE_DATA_WIDTH-1:0] byte_enable,
    input  logic [DATA_WIDTH-1:0]      data_addr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    output logic                       data_valid,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic                       err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t                     state_q, state_d;
    logic [3:0]                 count_q, count_d;
    logic                       we_q, we_d;
    logic [BYTE_DATA_WIDTH-1:0] be_q, be_d;
    logic [DEPTH_LOG2-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic                       oor_q, oor_d;
    logic                       data_valid_q, data_valid_d;
    logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
    logic                       err_q, err_d;

    logic [DATA_WIDTH-1:0] mem [1 << DEPTH_LOG2];

    logic                       in_oor;
    logic [DEPTH_LOG2-1:0]      in_idx;
    logic                       acc_we;
    logic [BYTE_DATA_WIDTH-1:0] acc_be;
    logic [DEPTH_LOG2-1:0]      acc_idx;
    logic [DATA_WIDTH-1:0]      acc_wdata;
    logic                       acc_oor;
    logic [DATA_WIDTH-1:0]      merged;
    logic                       enter_resp;
    logic                       commit;
    logic                       unused_addr_bits;

    assign unused_addr_bits = ^data_addr[1:0];
    assign in_oor           = |data_addr[DATA_WIDTH-1:DEPTH_LOG2+2];
    assign in_idx           = data_addr[DEPTH_LOG2+1:2];

    // With LATENCY=1 the response is issued straight from IDLE, so the
    // completing transaction's fields come from the inputs rather than the latches.
    always_comb begin
        acc_we    = we_q;
        acc_be    = be_q;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        acc_oor   = oor_q;
        if (state_q == IDLE) begin
            acc_we    = data_we;
            acc_be    = byte_enable;
            acc_idx   = in_idx;
            acc_wdata = wdata;
            acc_oor   = in_oor;
        end
        merged = mem[acc_idx];
        for (int i = 0; i < BYTE_DATA_WIDTH; i++) begin
            if (acc_be[i]) begin
                merged[8*i +: 8] = acc_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        we_d         = we_q;
        be_d         = be_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        oor_d        = oor_q;
        data_valid_d = 1'b0;
        err_d        = 1'b0;
        rdata_d      = rdata_q;
        enter_resp   = 1'b0;
        commit       = 1'b0;

        case (state_q)
            IDLE: begin
                if (data_req) begin
                    we_d    = data_we;
                    be_d    = byte_enable;
                    idx_d   = in_idx;
                    wdata_d = wdata;
                    oor_d   = in_oor;
                    count_d = LAT_M1;
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                count_d = count_q - 4'd1;
                if (count_q <= 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enter_resp) begin
            data_valid_d = 1'b1;
            err_d        = acc_oor;
            if (acc_we) begin
                commit = !acc_oor;
            end else begin
                rdata_d = acc_oor ? '0 : mem[acc_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            we_q         <= 1'b0;
            be_q         <= '0;
            idx_q        <= '0;
            wdata_q      <= '0;
            oor_q        <= 1'b0;
            data_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            we_q         <= we_d;
            be_q         <= be_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            oor_q        <= oor_d;
            data_valid_q <= data_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    // RAM contents survive reset; reset only blocks a pending commit.
    always_ff @(posedge clk) begin
        if (!rst && commit) begin
            mem[acc_idx] <= merged;
        end
    end

    assign data_valid = data_valid_q;
    assign rdata      = rdata_q;
    assign err        = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: vector table plus scoreboard
// for the LATENCY=2 instance, hand sequences for back-to-back, reset and LATENCY=1.
module tb_data_mem_responder;

    localparam int LAT = 2;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    logic        valid, err;
    logic [31:0] rdata;
    logic        req1, we1;
    logic [3:0]  be1;
    logic [31:0] addr1, wdata1;
    logic        valid1, err1;
    logic [31:0] rdata1;

    exp_t sbq[$];
    exp_t mon_e;
    int   valid_cycles[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    vec_t vecs[16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.DATA_WIDTH(32), .BYTE_DATA_WIDTH(4), .DEPTH_LOG2(10), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst), .data_req(req), .data_we(we), .byte_enable(be),
        .data_addr(addr), .wdata(wdata), .data_valid(valid), .rdata(rdata), .err(err)
    );

    data_mem_responder #(.DATA_WIDTH(32), .BYTE_DATA_WIDTH(4), .DEPTH_LOG2(10), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .data_req(req1), .data_we(we1), .byte_enable(be1),
        .data_addr(addr1), .wdata(wdata1), .data_valid(valid1), .rdata(rdata1), .err(err1)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every completion pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid) begin
                valid_cycles.push_back(cyc);
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    checkOutput("sb_rdata", rdata, mon_e.rdata);
                    checkOutput("sb_err", {31'd0, err}, {31'd0, mon_e.err});
                end
            end else if (err) begin
                checkOutput("err_without_valid", 32'd1, 32'd0);
            end
        end
    end

    task automatic waitValid(input string name, input int exp_lat);
        int  k;
        bit  seen;
        k    = 0;
        seen = 0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (valid) seen = 1;
        end
        if (seen) begin
            checkOutput({name, "_latency"}, 32'(k), 32'(exp_lat));
        end else begin
            checkOutput({name, "_timeout"}, 32'd0, 32'd1);
            sbq.delete();
        end
    endtask

    // One transaction; inputs are scrambled after acceptance so a response
    // built from live inputs instead of latched ones would miscompare.
    task automatic applyStimulus(input vec_t v, input string name);
        @(negedge clk);
        req   = 1'b1;
        we    = v.we;
        be    = v.be;
        addr  = v.addr;
        wdata = v.wdata;
        sbq.push_back('{v.exp_rdata, v.exp_err});
        @(posedge clk);
        #1;
        req   = 1'b0;
        we    = 1'($urandom);
        be    = 4'($urandom);
        addr  = $urandom;
        wdata = $urandom;
        waitValid(name, LAT);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 4'h2, 32'h0000_0010, 32'h0000_AA00, 32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{1'b0, 4'hF, 32'h0000_0012, 32'h0000_0000, 32'hDEAD_AAEF, 1'b0};
        vecs[4]  = '{1'b1, 4'hF, 32'h0000_0000, 32'h0000_0001, 32'hDEAD_AAEF, 1'b0};
        vecs[5]  = '{1'b1, 4'hF, 32'h0000_0004, 32'h0000_0002, 32'hDEAD_AAEF, 1'b0};
        vecs[6]  = '{1'b1, 4'hF, 32'h0000_0008, 32'h0000_0003, 32'hDEAD_AAEF, 1'b0};
        vecs[7]  = '{1'b1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF, 32'hDEAD_AAEF, 1'b0};
        vecs[8]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_AAEF, 1'b0};
        vecs[9]  = '{1'b0, 4'hF, 32'h0000_1000, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[10] = '{1'b1, 4'hF, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[11] = '{1'b0, 4'hF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 1'b0};
        vecs[12] = '{1'b1, 4'hF, 32'h0000_0020, 32'hA5A5_A5A5, 32'h0000_0001, 1'b0};
        vecs[13] = '{1'b0, 4'hF, 32'h8000_0010, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[14] = '{1'b1, 4'hF, 32'h0000_0FFC, 32'h1122_3344, 32'h0000_0000, 1'b0};
        vecs[15] = '{1'b0, 4'hF, 32'h0000_0FFF, 32'h0000_0000, 32'h1122_3344, 1'b0};

        rst = 1'b1;
        req = 1'b0;  we = 1'b0;  be = '0;  addr = '0;  wdata = '0;
        req1 = 1'b0; we1 = 1'b0; be1 = '0; addr1 = '0; wdata1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_valid", {31'd0, valid}, 32'd0);
        checkOutput("reset_rdata", rdata, 32'd0);
        checkOutput("reset_err", {31'd0, err}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back loads with data_req held high; address moved during WAIT.
        valid_cycles.delete();
        @(negedge clk);
        req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            sbq.push_back('{32'(i + 1), 1'b0});
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            addr = 32'h10;
            waitValid($sformatf("b2b%0d", i), LAT);
            if (i < 2) begin
                addr = 32'(4 * (i + 1));
                @(posedge clk);
                @(posedge clk);
            end else begin
                req = 1'b0;
            end
        end
        checkOutput("b2b_count", 32'(valid_cycles.size()), 32'd3);
        if (valid_cycles.size() == 3) begin
            checkOutput("b2b_gap0", 32'(valid_cycles[1] - valid_cycles[0]), 32'(LAT + 1));
            checkOutput("b2b_gap1", 32'(valid_cycles[2] - valid_cycles[1]), 32'(LAT + 1));
        end

        // Reset during WAIT of a store: no response, no commit, outputs cleared.
        @(negedge clk);
        req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h20; wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        req = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mid_valid", {31'd0, valid}, 32'd0);
        checkOutput("rst_mid_rdata", rdata, 32'd0);
        checkOutput("rst_mid_err", {31'd0, err}, 32'd0);
        checkOutput("rst_mid_rdata1", rdata1, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        applyStimulus('{1'b0, 4'hF, 32'h20, 32'h0, 32'hA5A5_A5A5, 1'b0}, "post_rst_load");
        applyStimulus('{1'b1, 4'h9, 32'h24, 32'h7700_0088, 32'hA5A5_A5A5, 1'b0}, "store_hold");

        // LATENCY=1 instance: store then immediate load of the same word.
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; be1 = 4'hF; addr1 = 32'h40; wdata1 = 32'hABCD_1234;
        @(posedge clk);
        @(negedge clk);
        checkOutput("l1_store_valid", {31'd0, valid1}, 32'd1);
        checkOutput("l1_store_err", {31'd0, err1}, 32'd0);
        checkOutput("l1_store_rdata", rdata1, 32'd0);
        we1 = 1'b0; be1 = 4'h0; wdata1 = 32'h0;
        @(negedge clk);
        checkOutput("l1_idle_valid", {31'd0, valid1}, 32'd0);
        @(negedge clk);
        checkOutput("l1_load_valid", {31'd0, valid1}, 32'd1);
        checkOutput("l1_load_rdata", rdata1, 32'hABCD_1234);
        req1 = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("sb_drained", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Responder (slave) end of the core's data-cache interface. It accepts load/store requests from the core's LSU, waits a fixed number of cycles, then completes each request with a one-cycle data_valid pulse. Stores are byte-lane masked into a local word-organised RAM; loads return the full word. It sits between the core's data port and on-chip data memory, and is also used as the bench memory model.

Parameters:
DATA_WIDTH, 32, data/address width in bits
BYTE_DATA_WIDTH, 4, number of byte lanes (DATA_WIDTH/8)
DEPTH_LOG2, 10, log2 of RAM depth in words (default 1024 words = 4 KiB)
LATENCY, 2, cycles from request acceptance to data_valid; legal range 1..15

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
data_req  input  1  request strobe from core; level, held until data_valid
data_we  input  1  1 = store, 0 = load
byte_enable  input  BYTE_DATA_WIDTH  store lane mask; bit i covers bits [8i+7:8i]
data_addr  input  DATA_WIDTH  byte address
wdata  input  DATA_WIDTH  store data
data_valid  output  1  one-cycle completion pulse
rdata  output  DATA_WIDTH  load data, valid when data_valid=1
err  output  1  one-cycle pulse coincident with data_valid for out-of-range access

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, counter=0, data_valid=0, rdata=0, err=0. RAM contents are not cleared. rst has priority over every other event.
- Addressing: word index = data_addr[DEPTH_LOG2+1:2]; data_addr[1:0] ignored (no misalignment handling). The access is out of range if any of data_addr[DATA_WIDTH-1:DEPTH_LOG2+2] is nonzero.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if data_req=1, accept. Latch we, byte_enable, word index, wdata and range flag. Load counter=LATENCY-1. Go to WAIT, or to RESP directly if LATENCY=1.
  - WAIT: decrement counter; go to RESP when counter reaches 1. Inputs are ignored; only latched values are used.
  - RESP: data_valid=1 for exactly this cycle, then return to IDLE.
- Timing: request accepted at edge T (data_req high in IDLE). data_valid is high during cycle T+LATENCY.
- Store commit: performed at the edge that enters RESP, using latched values. Each lane with byte_enable[i]=1 is written; other lanes are unchanged. byte_enable=0000 writes nothing but still completes normally. An out-of-range store writes nothing.
- Load: rdata is updated at the edge entering RESP with RAM[index]. It reflects all previously committed stores, including a store that completed in the immediately preceding transaction. byte_enable is ignored on loads. An out-of-range load returns 0.
- rdata holds its last load value through store responses and idle periods.
- err=1 only in the RESP cycle of an out-of-range access; otherwise 0.
- Back-to-back: the responder is IDLE in the cycle after RESP. If data_req is still 1 there, it is accepted as a new transaction. Minimum spacing between data_valid pulses is LATENCY+1 cycles.
- data_req asserted during WAIT or RESP has no effect until IDLE. data_req dropped mid-transaction does not cancel it; the response still issues.
- Reset mid-transaction: the transaction is aborted; no store is committed and no data_valid is issued.
- One outstanding transaction maximum; no queuing.

Test Plan:
- Store 0xDEADBEEF at addr 0x10, byte_enable=1111, accepted at edge T -> data_valid high during cycle T+2, err=0. Load 0x10 -> rdata=0xDEADBEEF with data_valid.
- After the above, store 0x0000AA00 at 0x10 with byte_enable=0010, then load 0x12 -> rdata=0xDEADAAEF (low address bits ignored).
- data_req held high for 3 loads of 0x0/0x4/0x8 preloaded 1/2/3 -> data_valid pulses exactly 3 cycles apart, rdata 1,2,3. Change data_addr during WAIT -> response still uses the latched address.
- Load 0x1000 (DEPTH_LOG2=10) -> data_valid and err both pulse, rdata=0. Store 0x1000 of 0xFFFFFFFF, then load 0x0 -> 0x0 is unchanged.
- Store 0x12345678 to 0x20; assert rst in the WAIT cycle -> no data_valid; subsequent load 0x20 returns the pre-store value. During rst, all outputs are 0.
- LATENCY=1 build: request at edge T -> data_valid during cycle T+1; store then immediate load of the same address returns the new data.
